// File: rtl/out_display_sched_if.sv
// out_display_sched_if: CPU OUT-strobe side and display side of the output scheduler.
interface out_display_sched_if #(parameter int BITS = 32, parameter int PTR = 2);
   logic            req;
   logic [BITS-1:0] req_value;
   logic            blank;
   logic            clr_overflow;
   logic            flagOUT;
   logic [BITS-1:0] Value;
   logic            full;
   logic [PTR:0]    count;
   logic            overflow;
   modport master (output req, req_value, blank, clr_overflow,
                   input flagOUT, Value, full, count, overflow);
   modport slave (input req, req_value, blank, clr_overflow,
                  output flagOUT, Value, full, count, overflow);
endinterface

// File: rtl/out_display_sched.sv
// out_display_sched: queues OUT values in a FIFO and shows each on the display
// for at least HOLD cycles; the last value stays up until a new one arrives.
module out_display_sched #(
   parameter int BITS   = 32,
   parameter int DEPTH  = 4,
   parameter int PTR    = 2,
   parameter int HOLD   = 50000000,
   parameter int HOLD_W = 26
) (
   input logic clock,
   input logic reset,
   out_display_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHOW, LAST} state_t;
   state_t            r_state, w_state_nx;
   logic [BITS-1:0]   r_mem [DEPTH];
   logic [PTR-1:0]    r_wr, r_rd;
   logic [PTR:0]      r_count;
   logic [HOLD_W-1:0] r_hold;
   logic [BITS-1:0]   r_value;
   logic              r_flag, r_ovf;
   logic              w_full, w_avail, w_expired, w_pop, w_push;
   assign w_full    = r_count == (PTR+1)'(DEPTH);
   assign w_avail   = r_count != '0;
   assign w_expired = r_hold == '0;
   // IDLE/LAST pop as soon as data exists; SHOW waits for the hold to run out
   assign w_pop     = w_avail & ((r_state != SHOW) | w_expired);
   assign w_push    = bus.req & (~w_full | w_pop);
   assign w_state_nx = w_pop ? SHOW : (r_state == SHOW && w_expired) ? LAST : r_state;
   always_ff @(posedge clock)
      if (w_push) r_mem[r_wr] <= bus.req_value;
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_state <= IDLE;
         r_hold  <= '0;
         r_value <= '0;
         r_flag  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
         r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
         r_count <= r_count + {{PTR{1'b0}}, w_push} - {{PTR{1'b0}}, w_pop};
         r_state <= w_state_nx;
         r_hold  <= w_pop ? HOLD_W'(HOLD - 1) :
                    (r_state == SHOW && !w_expired) ? r_hold - HOLD_W'(1) : r_hold;
         r_value <= w_pop ? r_mem[r_rd] : r_value;
         r_flag  <= (w_state_nx != IDLE) & ~bus.blank;
         r_ovf   <= (bus.req & ~w_push) | (r_ovf & ~bus.clr_overflow);
      end
   end
   assign bus.flagOUT  = r_flag;
   assign bus.Value    = r_value;
   assign bus.full     = w_full;
   assign bus.count    = r_count;
   assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_out_display_sched.sv
// tb_out_display_sched: directed vectors with hand-computed expectations, HOLD=4, DEPTH=4.
module tb_out_display_sched;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   out_display_sched_if #(.BITS(32), .PTR(2)) bus ();
   out_display_sched #(.BITS(32), .DEPTH(4), .PTR(2), .HOLD(4), .HOLD_W(3)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask
   task automatic do_reset();
      reset = 1'b0;
      bus.req = 1'b0;
      bus.req_value = '0;
      bus.blank = 1'b0;
      bus.clr_overflow = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask
   initial begin
      do_reset();
      check("rst_flag", 32'(bus.flagOUT), 0);
      check("rst_value", bus.Value, 0);
      check("rst_count", 32'(bus.count), 0);
      check("rst_full", 32'(bus.full), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      // single value, then held in LAST
      bus.req = 1'b1; bus.req_value = 123; tick();
      bus.req = 1'b0;
      check("one_e1_count", 32'(bus.count), 1);
      check("one_e1_flag", 32'(bus.flagOUT), 0);
      tick();
      check("one_e2_flag", 32'(bus.flagOUT), 1);
      check("one_e2_value", bus.Value, 123);
      check("one_e2_count", 32'(bus.count), 0);
      tick(10);
      check("one_last_flag", 32'(bus.flagOUT), 1);
      check("one_last_value", bus.Value, 123);
      // three values back to back
      do_reset();
      for (int e = 1; e <= 18; e++) begin
         bus.req = e <= 3;
         bus.req_value = 32'(e + 4);
         tick();
         bus.req = 1'b0;
         check($sformatf("seq_val_e%0d", e), bus.Value,
               e < 2 ? 0 : e < 6 ? 5 : e < 10 ? 6 : 7);
         check($sformatf("seq_flag_e%0d", e), 32'(bus.flagOUT), e >= 2);
      end
      // fill past full: value 6 dropped
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         bus.req = e <= 7;
         bus.req_value = 32'(e - 1);
         tick();
         bus.req = 1'b0;
         if (e >= 2) check($sformatf("ovf_val_e%0d", e), bus.Value, (e - 2) / 4 > 5 ? 5 : (e - 2) / 4);
         if (e == 4) check("ovf_full_e4", 32'(bus.full), 0);
         if (e == 5) check("ovf_full_e5", 32'(bus.full), 1);
         if (e == 6) check("ovf_count_e6", 32'(bus.count), 4);
         if (e == 6) check("ovf_flag_e6", 32'(bus.overflow), 0);
         if (e == 7) check("ovf_flag_e7", 32'(bus.overflow), 1);
         if (e == 7) check("ovf_count_e7", 32'(bus.count), 4);
         if (e == 26) check("ovf_count_e26", 32'(bus.count), 0);
      end
      // blank during SHOW of 5
      do_reset();
      bus.req = 1'b1; bus.req_value = 5; tick();
      bus.req_value = 6; tick();
      bus.req = 1'b0;
      bus.blank = 1'b1;
      for (int e = 3; e <= 6; e++) begin
         if (e == 6) bus.blank = 1'b0;
         tick();
         check($sformatf("blank_flag_e%0d", e), 32'(bus.flagOUT), e == 6);
         check($sformatf("blank_val_e%0d", e), bus.Value, e < 6 ? 5 : 6);
      end
      // reset mid-show discards queue
      do_reset();
      for (int e = 1; e <= 3; e++) begin
         bus.req = 1'b1; bus.req_value = 32'(e); tick();
      end
      bus.req = 1'b0;
      check("mid_count_pre", 32'(bus.count), 2);
      reset = 1'b0; tick(); reset = 1'b1;
      check("mid_flag", 32'(bus.flagOUT), 0);
      check("mid_value", bus.Value, 0);
      check("mid_count", 32'(bus.count), 0);
      check("mid_ovf", 32'(bus.overflow), 0);
      tick(10);
      check("mid_late_flag", 32'(bus.flagOUT), 0);
      check("mid_late_value", bus.Value, 0);
      // overflow set wins over clear, then clear alone
      do_reset();
      for (int e = 1; e <= 7; e++) begin
         bus.req = 1'b1; bus.req_value = 32'(e); tick();
      end
      check("clr_pre", 32'(bus.overflow), 1);
      bus.clr_overflow = 1'b1; tick();
      bus.req = 1'b0;
      check("clr_with_drop", 32'(bus.overflow), 1);
      check("clr_count", 32'(bus.count), 4);
      tick();
      bus.clr_overflow = 1'b0;
      check("clr_alone", 32'(bus.overflow), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/out_display_sched.md
Name: out_display_sched

Overview:
- Sequences processor OUT-instruction results onto the 7-segment output stage.
- Each write (value plus one-cycle strobe) is queued in a small FIFO.
- Each queued value is presented on Value/flagOUT for a minimum hold time so a human can read it; the last value stays displayed until a new one arrives.
- Sits between the CPU datapath's OUT strobe and the display/BCD block, which consumes flagOUT and Value.

Parameters:
- BITS, 32, width of queued and displayed value
- DEPTH, 4, FIFO entries (power of two, >=2)
- PTR, 2, log2(DEPTH)
- HOLD, 50000000, minimum display cycles per value (>=1)
- HOLD_W, 26, counter width (2^HOLD_W > HOLD)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- req  input  1  one-cycle write strobe from OUT instruction
- req_value  input  BITS  value to display, sampled when req=1
- blank  input  1  1 forces display off; sequencing continues
- clr_overflow  input  1  clears overflow flag
- flagOUT  output  1  display enable to output stage (registered)
- Value  output  BITS  value to output stage (registered)
- full  output  1  FIFO count == DEPTH
- count  output  PTR+1  FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky: a req was dropped

Behaviour:
- Reset (reset==0 at a clock edge): FIFO emptied (count=0, pointers 0), state IDLE, hold counter 0, flagOUT=0, Value=0, overflow=0. Reset mid-operation discards all queued entries; none are ever displayed.
- Push: req=1 at an edge writes req_value at the write pointer and count+1.
  - If full and no pop occurs in the same cycle, the write is dropped and overflow<=1.
  - If full and a pop occurs in the same cycle, the write is accepted; count is unchanged.
  - Push and pop in the same cycle with count in 1..DEPTH-1: count unchanged.
- Pop: the FSM reads the head entry into Value and reloads the hold counter with HOLD-1. Pointers wrap modulo DEPTH.
- No bypass: an entry is visible to the FSM only the edge after it is written.
- Latency: req at edge n into an empty FIFO in IDLE/LAST gives Value updated and flagOUT=1 after edge n+1.
- FSM states (2-bit encoding):
  - IDLE: flagOUT=0, Value holds. If count>0: pop, go SHOW.
  - SHOW: counter decrements by 1 per cycle. When counter==0: if count>0, pop and stay in SHOW; else go LAST. A new value never preempts before its hold expires.
  - LAST: Value and flagOUT held. If count>0: pop, go SHOW.
- flagOUT register: next value = (state_next != IDLE) & ~blank.
  - blank affects flagOUT only, one cycle after it changes.
  - Counter, FIFO and Value keep advancing while blanked.
- overflow: set by a dropped push and cleared by clr_overflow. A simultaneous set and clear leaves it at 1 (set wins).
- HOLD=1: each value is shown for exactly one cycle; back-to-back pops on consecutive edges are legal.
- full and count are combinational decodes of registered occupancy.
- Unsigned width rules: count is PTR+1 bits. The counter never underflows, because the decrement happens only when nonzero.

Test Plan:
- Bench parameters: HOLD=4, DEPTH=4.
- Reset, then req with value 123 at edge 1 -> after edge 2, flagOUT=1 and Value=123. Both held indefinitely (LAST); count returns to 0.
- req with 5, 6, 7 at edges 1..3 -> Value=5 after edges 2..5, 6 after edges 6..9, 7 from edge 10 onward. flagOUT stays 1 throughout.
- 7 reqs (values 0..6) at edges 1..7 -> full=1 after edge 5. Edge 6 push and pop are simultaneous (accepted). Edge 7 value 6 is dropped, overflow=1. Displayed sequence is 0..5 only.
- blank=1 for 3 cycles during SHOW of value 5 (queue 5, 6) -> flagOUT=0 one cycle after blank rises and 1 one cycle after it falls. Value changes to 6 on schedule regardless of blank.
- reset=0 for one edge while showing with 2 entries queued -> next cycle flagOUT=0, Value=0, count=0, overflow=0. The queued values never appear.
- overflow=1, then clr_overflow together with a dropping req -> overflow stays 1. clr_overflow alone -> overflow=0 next cycle.
